pwm_fade_ctrl: RTL and testbench

Duty-cycle sequencer for the 12-bit PWM generator. On a start command it ramps the PWM duty from its current value toward a target in fixed steps, one step per PWM period, holds at the target for a programmed number of periods, then signals completion. Its `oDuty` output drives the PWM's `iDuty` input. Its internal period counter runs in lockstep with the PWM counter, so every duty change lands exactly on a PWM period boundary.

---
 rtl/pwm_ctrl_pkg.sv | 14 +
 rtl/pwm_period_timer.sv | 22 ++
 rtl/pwm_fade_ctrl.sv | 143 ++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default widths for the PWM control blocks.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } fadeState_t;

  localparam int DUTY_W_DEF   = 12;
  localparam int PERIOD_W_DEF = 12;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter with an all-ones tick decode.
// Shared with the PWM generator so both stay in lockstep out of reset.
module pwm_period_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic iCLK,
  input  logic inReset,
  output logic oTick
);

  logic [PERIOD_W-1:0] count;

  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) count <= '0;
    else          count <= count + PERIOD_W'(1);
  end

  assign oTick = &count;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade sequencer: ramps oDuty toward a target one step per PWM period.
// Define PWM_FADE_BREATHE_EN to add endless target/floor breathing.
//
// state | meaning
// IDLE  | waiting for iStart, oDuty holds its last value
// RAMP  | stepping oDuty toward the active target on each tick
// HOLD  | counting hold periods at the target
// DONE  | single cycle after completion, oDone high
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int STEP_W   = 8,
  parameter int HOLD_W   = 8
) (
  input  logic              iCLK,
  input  logic              inReset,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic [DUTY_W-1:0] iTarget,
  input  logic [STEP_W-1:0] iStep,
  input  logic [HOLD_W-1:0] iHold,
`ifdef PWM_FADE_BREATHE_EN
  input  logic              iBreathe,
  input  logic [DUTY_W-1:0] iFloor,
`endif
  output logic [DUTY_W-1:0] oDuty,
  output logic              oBusy,
  output logic              oDone,
  output logic              oPeriodTick
);

  fadeState_t        state, stateNext;
  logic              tick;
  logic              startOk;
  logic [DUTY_W-1:0] target;
  logic [STEP_W-1:0] stepReg;
  logic [HOLD_W-1:0] holdLoad, holdCnt;
  logic              rampUp, reached;
  logic [DUTY_W:0]   delta, stepExt;
  logic [DUTY_W-1:0] dutyStepped, dutyNext;
  logic              busyNext, doneNext, breatheOn;
`ifdef PWM_FADE_BREATHE_EN
  logic              breathe;
  logic [DUTY_W-1:0] floorVal;
  assign breatheOn = breathe;
`else
  assign breatheOn = 1'b0;
`endif

  pwm_period_timer #(.PERIOD_W(PERIOD_W)) uTimer (
    .iCLK    (iCLK),
    .inReset (inReset),
    .oTick   (tick)
  );

  assign oPeriodTick = tick;
  assign startOk     = (state == IDLE) && iStart && !iAbort;

  // Distance to target is taken one bit wider so the step can saturate instead of wrapping.
  assign rampUp      = oDuty < target;
  assign stepExt     = (DUTY_W+1)'(stepReg);
  assign delta       = rampUp ? ({1'b0, target} - {1'b0, oDuty}) : ({1'b0, oDuty} - {1'b0, target});
  assign reached     = stepExt >= delta;
  assign dutyStepped = reached ? target
                     : (rampUp ? oDuty + DUTY_W'(stepReg) : oDuty - DUTY_W'(stepReg));

  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (iAbort) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: if (iStart) stateNext = RAMP;
        RAMP: if (tick && reached) stateNext = (holdLoad != '0) ? HOLD : DONE;
        HOLD: if (tick && holdCnt <= HOLD_W'(1)) stateNext = breatheOn ? RAMP : DONE;
        DONE: stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    dutyNext = oDuty;
    busyNext = (stateNext == RAMP) || (stateNext == HOLD);
    doneNext = (stateNext == DONE);
    if (!iAbort && state == RAMP && tick) dutyNext = dutyStepped;
  end

  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) begin
      oDuty <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oDuty <= dutyNext;
      oBusy <= busyNext;
      oDone <= doneNext;
    end
  end

  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) begin
      target   <= '0;
      stepReg  <= STEP_W'(1);
      holdLoad <= '0;
      holdCnt  <= '0;
`ifdef PWM_FADE_BREATHE_EN
      breathe  <= 1'b0;
      floorVal <= '0;
`endif
    end else if (startOk) begin
      target   <= iTarget;
      stepReg  <= (iStep == '0) ? STEP_W'(1) : iStep;
      holdLoad <= iHold;
      holdCnt  <= iHold;
`ifdef PWM_FADE_BREATHE_EN
      breathe  <= iBreathe;
      floorVal <= iFloor;
`endif
    end else if (!iAbort && tick) begin
      if (state == RAMP && reached) begin
        holdCnt <= holdLoad;
      end else if (state == HOLD) begin
        holdCnt <= holdCnt - HOLD_W'(1);
`ifdef PWM_FADE_BREATHE_EN
        // Swap ends of the breath; hold is reloaded when RAMP next reaches the new target.
        if (breathe && holdCnt <= HOLD_W'(1)) begin
          target   <= floorVal;
          floorVal <= target;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl with a 16-cycle PWM period.
module tb_pwm_fade_ctrl;

  logic        iCLK = 1'b0;
  logic        inReset = 1'b0;
  logic        iStart = 1'b0;
  logic        iAbort = 1'b0;
  logic [11:0] iTarget = '0;
  logic [7:0]  iStep = '0;
  logic [7:0]  iHold = '0;
`ifdef PWM_FADE_BREATHE_EN
  logic        iBreathe = 1'b0;
  logic [11:0] iFloor = '0;
`endif
  logic [11:0] oDuty;
  logic        oBusy, oDone, oPeriodTick;

  int checks = 0, failures = 0;
  int phase = 0;
  bit lastEdgeTick = 0;
  int modelDuty = 0;
  int doneSeen = 0, doneExp = 0;

  pwm_fade_ctrl #(.DUTY_W(12), .PERIOD_W(4), .STEP_W(8), .HOLD_W(8)) dut (
    .iCLK        (iCLK),
    .inReset     (inReset),
    .iStart      (iStart),
    .iAbort      (iAbort),
    .iTarget     (iTarget),
    .iStep       (iStep),
    .iHold       (iHold),
`ifdef PWM_FADE_BREATHE_EN
    .iBreathe    (iBreathe),
    .iFloor      (iFloor),
`endif
    .oDuty       (oDuty),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oPeriodTick (oPeriodTick)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) if (inReset && oDone === 1'b1) doneSeen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: tick checked against the bench's own period position, then the edge.
  task automatic clk1();
    @(negedge iCLK);
    chk("period_tick", 32'(oPeriodTick), 32'(phase == 15));
    @(posedge iCLK);
    lastEdgeTick = (phase == 15);
    phase = (phase + 1) % 16;
    #1;
  endtask

  task automatic waitTick();
    bit got = 0;
    for (int i = 0; i < 17 && !got; i++) begin
      clk1();
      if (lastEdgeTick) got = 1;
      else chk("duty_steady", 32'(oDuty), 32'(modelDuty));
    end
    if (!got) begin
      checks++;
      failures++;
      $error("FAIL tick_timeout observed=none expected=tick");
    end
  endtask

  function automatic int stepTo(int cur, int tgt, int s);
    if (cur < tgt) return (cur + s > tgt) ? tgt : cur + s;
    if (cur > tgt) return (cur - s < tgt) ? tgt : cur - s;
    return cur;
  endfunction

  task automatic runFade(input int tgt, input int step, input int hold, input bit align);
    int s;
    s = (step == 0) ? 1 : step;
    if (align) for (int i = 0; i < 16 && phase != 15; i++) clk1();
    iTarget = 12'(tgt); iStep = 8'(step); iHold = 8'(hold); iStart = 1'b1;
    clk1();
    iStart = 1'b0;
    chk("busy_after_start", 32'(oBusy), 1);
    chk("duty_at_start", 32'(oDuty), 32'(modelDuty));
    do begin
      waitTick();
      modelDuty = stepTo(modelDuty, tgt, s);
      chk("ramp_duty", 32'(oDuty), 32'(modelDuty));
      if (modelDuty != tgt || hold > 0) chk("ramp_busy", 32'(oBusy), 1);
    end while (modelDuty != tgt);
    for (int h = 0; h < hold; h++) begin
      waitTick();
      chk("hold_duty", 32'(oDuty), 32'(modelDuty));
      if (h < hold - 1) chk("hold_busy", 32'(oBusy), 1);
    end
    chk("done_pulse", 32'(oDone), 1);
    chk("busy_drop", 32'(oBusy), 0);
    doneExp++;
    clk1();
    chk("done_width", 32'(oDone), 0);
    chk("done_count", 32'(doneSeen), 32'(doneExp));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_duty", 32'(oDuty), 0);
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_done", 32'(oDone), 0);
    chk("rst_tick", 32'(oPeriodTick), 0);
    inReset = 1'b1;
    phase = 0;

    // Basic ramp, saturating down, zero step, no-op
    runFade(100, 25, 2, 0);
    runFade(10, 40, 0, 0);
    runFade(13, 0, 0, 0);
    runFade(13, 0, 0, 0);
    runFade(0, 255, 0, 0);

    // Ignored start mid-ramp, then abort at duty 50
    iTarget = 12'd200; iStep = 8'd25; iHold = 8'd0; iStart = 1'b1;
    clk1();
    iStart = 1'b0;
    waitTick(); modelDuty = 25;
    chk("abort_ramp1", 32'(oDuty), 25);
    repeat (4) clk1();
    iTarget = 12'd7; iStep = 8'd99; iStart = 1'b1;
    clk1();
    iStart = 1'b0;
    chk("ignored_start_busy", 32'(oBusy), 1);
    waitTick(); modelDuty = 50;
    chk("ignored_start_step", 32'(oDuty), 50);
    repeat (3) clk1();
    iAbort = 1'b1;
    clk1();
    iAbort = 1'b0;
    chk("abort_busy", 32'(oBusy), 0);
    chk("abort_duty", 32'(oDuty), 50);
    waitTick(); waitTick();
    chk("abort_frozen", 32'(oDuty), 50);
    chk("abort_no_done", 32'(doneSeen), 32'(doneExp));

    // Start coincident with a tick, then saturation at full scale
    runFade(4000, 255, 0, 1);
    runFade(4095, 255, 1, 0);

    // Randomized fades against the model
    for (int r = 0; r < 6; r++)
      runFade(int'($urandom_range(4095, 0)), int'($urandom_range(255, 64)),
              int'($urandom_range(2, 0)), bit'($urandom_range(1, 0)));

    // Asynchronous reset mid-hold
    iTarget = 12'(modelDuty); iStep = 8'd1; iHold = 8'd3; iStart = 1'b1;
    clk1();
    iStart = 1'b0;
    waitTick();
    waitTick();
    chk("pre_reset_busy", 32'(oBusy), 1);
    #3 inReset = 1'b0;
    #1;
    chk("async_rst_duty", 32'(oDuty), 0);
    chk("async_rst_busy", 32'(oBusy), 0);
    chk("async_rst_done", 32'(oDone), 0);
    repeat (2) @(posedge iCLK);
    #1 inReset = 1'b1;
    phase = 0;
    modelDuty = 0;
    repeat (15) clk1();
    chk("first_tick_cycle15", 32'(oPeriodTick), 1);
    clk1();
    chk("post_reset_done", 32'(doneSeen), 32'(doneExp));

`ifdef PWM_FADE_BREATHE_EN
    begin
      int tgt, flo, tmp, holdLeft;
      bit inHold;
      tgt = 80; flo = 20; inHold = 0; holdLeft = 0;
      iTarget = 12'd80; iFloor = 12'd20; iStep = 8'd20; iHold = 8'd1; iBreathe = 1'b1; iStart = 1'b1;
      clk1();
      iStart = 1'b0; iBreathe = 1'b0;
      for (int t = 0; t < 20; t++) begin
        waitTick();
        if (inHold) begin
          holdLeft--;
          if (holdLeft == 0) begin
            tmp = tgt; tgt = flo; flo = tmp; inHold = 0;
          end
        end else begin
          modelDuty = stepTo(modelDuty, tgt, 20);
          if (modelDuty == tgt) begin inHold = 1; holdLeft = 1; end
        end
        chk("breathe_duty", 32'(oDuty), 32'(modelDuty));
        chk("breathe_busy", 32'(oBusy), 1);
      end
      chk("breathe_no_done", 32'(doneSeen), 32'(doneExp));
      iAbort = 1'b1;
      clk1();
      iAbort = 1'b0;
      chk("breathe_abort_busy", 32'(oBusy), 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
